// File: rtl/muldiv_seq_if.sv
// Handshake/bus interface between the execute stage and the multi-cycle
// multiply/divide sequencer.
//   master : execute stage  (drives start, funct3, op1, op2)
//   slave  : muldiv_seq     (drives busy, stall, done, result)
interface muldiv_seq_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [2:0]            funct3;
   logic [DATA_WIDTH-1:0] op1;
   logic [DATA_WIDTH-1:0] op2;
   logic                  busy;
   logic                  stall;
   logic                  done;
   logic [DATA_WIDTH-1:0] result;

   modport master (
      output start, funct3, op1, op2,
      input  busy, stall, done, result
   );

   modport slave (
      input  start, funct3, op1, op2,
      output busy, stall, done, result
   );
endinterface

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer. Iterative shift-add multiply
// and restoring divide on operand magnitudes, signs restored in FIXUP.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset, aborts any in-flight op
//   bus  - muldiv_seq_if.slave: start/funct3/op1/op2 in,
//          busy/stall/done/result out
module muldiv_seq #(
   parameter int DATA_WIDTH = 32
) (
   input logic         clk,
   input logic         rst,
   muldiv_seq_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PREP  = 3'd1;
   localparam logic [2:0] S_CALC  = 3'd2;
   localparam logic [2:0] S_FIXUP = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [2:0] F_MUL    = 3'b000;
   localparam logic [2:0] F_MULH   = 3'b001;
   localparam logic [2:0] F_MULHSU = 3'b010;
   localparam logic [2:0] F_MULHU  = 3'b011;
   localparam logic [2:0] F_DIV    = 3'b100;
   localparam logic [2:0] F_DIVU   = 3'b101;
   localparam logic [2:0] F_REM    = 3'b110;

   typedef struct packed {
      logic [2:0]   fn;
      logic [W-1:0] a;
      logic [W-1:0] b;
   } req_t;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   req_t          req;
   logic [W-1:0]  mag_a;    // multiplicand magnitude
   logic [W-1:0]  mag_b;    // divisor magnitude
   logic [2*W-1:0] prod;    // {partial sum, remaining multiplier bits}
   logic [W:0]    rem;      // extra bit absorbs the trial-subtract borrow
   logic [W-1:0]  quo;      // dividend shifts out the top, quotient in the bottom
   logic          neg_res;
   logic          neg_rem;
   logic [W-1:0]  res;

   // operand conditioning, evaluated from the latched request during PREP
   logic         signed_a, signed_b, sgn_a, sgn_b;
   logic [W-1:0] abs_a, abs_b;
   logic         is_div, div_zero, div_ovf;

   always_comb begin
      signed_a = 1'b0;
      signed_b = 1'b0;
      case (req.fn)
         F_MULH, F_DIV, F_REM: begin
            signed_a = 1'b1;
            signed_b = 1'b1;
         end
         F_MULHSU: signed_a = 1'b1;
         default: ;
      endcase
   end

   assign sgn_a    = signed_a & req.a[W-1];
   assign sgn_b    = signed_b & req.b[W-1];
   assign abs_a    = sgn_a ? -req.a : req.a;
   assign abs_b    = sgn_b ? -req.b : req.b;
   assign is_div   = req.fn[2];
   assign div_zero = is_div && (req.b == '0);
   // most-negative / -1 overflows the signed quotient; RV32M pins the result
   assign div_ovf  = (req.fn == F_DIV || req.fn == F_REM) &&
                     (req.a == {1'b1, {(W-1){1'b0}}}) && (req.b == '1);

   // one iteration of each datapath
   logic [W:0] mul_sum, div_sh, div_diff;

   assign mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mag_a} : {(W+1){1'b0}});
   assign div_sh   = (rem << 1) | {{W{1'b0}}, quo[W-1]};
   assign div_diff = div_sh - {1'b0, mag_b};

   // sign restoration
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo_fix, rem_fix;

   assign prod_fix = neg_res ? -prod : prod;
   assign quo_fix  = neg_res ? -quo : quo;
   assign rem_fix  = neg_rem ? -rem[W-1:0] : rem[W-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         req     <= '0;
         mag_a   <= '0;
         mag_b   <= '0;
         prod    <= '0;
         rem     <= '0;
         quo     <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         res     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  req   <= '{fn: bus.funct3, a: bus.op1, b: bus.op2};
                  state <= S_PREP;
               end
            end
            S_PREP: begin
               if (div_zero) begin
                  res   <= req.fn[1] ? req.a : '1;
                  state <= S_DONE;
               end else if (div_ovf) begin
                  res   <= req.fn[1] ? '0 : req.a;
                  state <= S_DONE;
               end else begin
                  mag_a   <= abs_a;
                  mag_b   <= abs_b;
                  neg_res <= sgn_a ^ sgn_b;
                  neg_rem <= sgn_a;
                  prod    <= {{W{1'b0}}, abs_b};
                  quo     <= abs_a;
                  rem     <= '0;
                  cnt     <= '0;
                  state   <= S_CALC;
               end
            end
            S_CALC: begin
               if (is_div) begin
                  // borrow set means the trial subtract failed: restore
                  rem <= div_diff[W] ? div_sh : div_diff;
                  quo <= {quo[W-2:0], ~div_diff[W]};
               end else begin
                  prod <= {mul_sum, prod[W-1:1]};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CW'(W-1)) state <= S_FIXUP;
            end
            S_FIXUP: begin
               case (req.fn)
                  F_MUL:                   res <= prod_fix[W-1:0];
                  F_MULH, F_MULHSU, F_MULHU: res <= prod_fix[2*W-1:W];
                  F_DIV, F_DIVU:           res <= quo_fix;
                  default:                 res <= rem_fix;
               endcase
               state <= S_DONE;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy   = (state != S_IDLE);
   assign bus.done   = (state == S_DONE);
   assign bus.stall  = (bus.start && state == S_IDLE) || state == S_PREP ||
                       state == S_CALC || state == S_FIXUP;
   assign bus.result = res;
endmodule
